// File: rtl/alu_result_accumulator.sv
// alu_result_accumulator
// Consumes the ALU result stream (Y plus mode tag), folds a fixed-length
// batch of counted results into a saturating sum with min/max tracking,
// and offers the batch summary to the readout stage.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. Ready never depends combinationally on valid on either side.
// in_ready and out_valid are registered and change only on clock edges
// (or on asynchronous reset).
module alu_result_accumulator #(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 10,
  parameter int N_SAMPLES = 4,
  parameter int CNT_W     = $clog2(N_SAMPLES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_y,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  sum,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] max_y,
  output logic [DATA_W-1:0] min_y,
  output logic              sat,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0]  SUM_MAX  = {ACC_W{1'b1}};
  localparam logic [DATA_W-1:0] MIN_INIT = {DATA_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_SAMPLES);
  localparam logic [1:0]        MODE_NOP = 2'b11;

  state_t            state;
  logic              accept;
  logic              counted;
  logic [ACC_W:0]    sum_wide;
  logic              sum_ovf;
  logic [CNT_W-1:0]  count_inc;
  logic              batch_full;
  logic [DATA_W-1:0] max_next;
  logic [DATA_W-1:0] min_next;

  assign fsm_state = state;

  // Datapath for one counted sample: widened add for overflow, min/max, count.
  always_comb begin
    accept     = in_valid & in_ready;
    counted    = accept & (in_mode != MODE_NOP);
    sum_wide   = {1'b0, sum} + {{(ACC_W + 1 - DATA_W){1'b0}}, in_y};
    sum_ovf    = sum_wide[ACC_W];
    count_inc  = count + CNT_W'(1);
    batch_full = (count_inc == CNT_LAST);
    max_next   = (in_y > max_y) ? in_y : max_y;
    min_next   = (in_y < min_y) ? in_y : min_y;
  end

  // Batch FSM with registered accumulators and handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sum       <= '0;
      count     <= '0;
      max_y     <= '0;
      min_y     <= MIN_INIT;
      sat       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else if (clear) begin
      // Abort wins over any simultaneous accept or summary handshake.
      state     <= IDLE;
      sum       <= '0;
      count     <= '0;
      max_y     <= '0;
      min_y     <= MIN_INIT;
      sat       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          // No-op (mode 11) samples are consumed without touching anything.
          if (counted) begin
            if (sum_ovf) begin
              sum <= SUM_MAX;
              sat <= 1'b1;
            end else begin
              sum <= sum_wide[ACC_W-1:0];
            end
            count <= count_inc;
            max_y <= max_next;
            min_y <= min_next;
            if (batch_full) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        DONE: begin
          // Summary is frozen until the readout stage takes it.
          if (out_ready) begin
            state     <= IDLE;
            sum       <= '0;
            count     <= '0;
            max_y     <= '0;
            min_y     <= MIN_INIT;
            sat       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_accumulator.sv
// Bench for alu_result_accumulator: two instances share one stimulus stream,
// the default build (ACC_W=10) and a narrow-sum build (ACC_W=8) that can
// saturate. A batch-level reference model (queue of counted samples) gives
// expected values; directed tables and hand sequences cover corner cases.
module tb_alu_result_accumulator;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       clear, in_valid, out_ready;
  logic [7:0] in_y;
  logic [1:0] in_mode;

  logic       in_ready_a, out_valid_a, sat_a;
  logic [9:0] sum_a;
  logic [2:0] count_a;
  logic [7:0] max_a, min_a;
  logic [1:0] state_a;

  logic       in_ready_b, out_valid_b, sat_b;
  logic [7:0] sum_b;
  logic [2:0] count_b;
  logic [7:0] max_b, min_b;
  logic [1:0] state_b;

  alu_result_accumulator dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_y(in_y), .in_mode(in_mode),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .sum(sum_a), .count(count_a), .max_y(max_a), .min_y(min_a), .sat(sat_a),
    .fsm_state(state_a)
  );

  alu_result_accumulator #(.ACC_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_y(in_y), .in_mode(in_mode),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .sum(sum_b), .count(count_b), .max_y(max_b), .min_y(min_b), .sat(sat_b),
    .fsm_state(state_b)
  );

  // ---------------- scoreboard ----------------
  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;
  logic [7:0] exp_q[$];   // counted samples of the current batch

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int unsigned m_total();
    int unsigned s = 0;
    foreach (exp_q[i]) s += exp_q[i];
    return s;
  endfunction

  function automatic int unsigned m_max();
    int unsigned m = 0;
    foreach (exp_q[i]) if (exp_q[i] > m) m = exp_q[i];
    return m;
  endfunction

  function automatic int unsigned m_min();
    int unsigned m = 255;
    foreach (exp_q[i]) if (exp_q[i] < m) m = exp_q[i];
    return m;
  endfunction

  function automatic bit m_done();
    return exp_q.size() == N;
  endfunction

  // Model reaction to one clock edge with the inputs currently driven.
  task automatic model_edge();
    if (clear) exp_q.delete();
    else if (m_done()) begin
      if (out_ready) exp_q.delete();
    end else if (in_valid && in_mode != 2'b11) exp_q.push_back(in_y);
  endtask

  task automatic check_model(input string tag);
    int unsigned t = m_total();
    bit d = m_done();
    check({tag, ".in_ready_a"}, in_ready_a, !d);
    check({tag, ".out_valid_a"}, out_valid_a, d);
    check({tag, ".sum_a"}, sum_a, (t > 1023) ? 1023 : t);
    check({tag, ".sat_a"}, sat_a, t > 1023);
    check({tag, ".count_a"}, count_a, exp_q.size());
    check({tag, ".max_a"}, max_a, m_max());
    check({tag, ".min_a"}, min_a, m_min());
    check({tag, ".out_valid_b"}, out_valid_b, d);
    check({tag, ".sum_b"}, sum_b, (t > 255) ? 255 : t);
    check({tag, ".sat_b"}, sat_b, t > 255);
    check({tag, ".min_b"}, min_b, m_min());
    check({tag, ".max_b"}, max_b, m_max());
  endtask

  // ---------------- driver ----------------
  // Drive inputs, take one edge, sample 1 time unit after it.
  task automatic apply(input logic v, input logic [7:0] y, input logic [1:0] m,
                       input logic clr, input logic ordy);
    in_valid  = v;
    in_y      = y;
    in_mode   = m;
    clear     = clr;
    out_ready = ordy;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic feed(input logic [7:0] y, input logic [1:0] m, input string tag);
    apply(1'b1, y, m, 1'b0, 1'b0);
    check_model(tag);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        v;
    logic [7:0]  y;
    logic [1:0]  m;
    logic        clr;
    logic        ordy;
    logic        e_ov;
    int unsigned e_sum;
    int unsigned e_cnt;
    int unsigned e_max;
    int unsigned e_min;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic [7:0] y, input logic [1:0] m,
                              input logic clr, input logic ordy, input logic e_ov,
                              input int unsigned e_sum, input int unsigned e_cnt,
                              input int unsigned e_max, input int unsigned e_min);
    vec_t r;
    r.v = v; r.y = y; r.m = m; r.clr = clr; r.ordy = ordy; r.e_ov = e_ov;
    r.e_sum = e_sum; r.e_cnt = e_cnt; r.e_max = e_max; r.e_min = e_min;
    return r;
  endfunction

  initial begin
    in_valid = 0; in_y = 0; in_mode = 0; clear = 0; out_ready = 0;

    // Nominal batch, then summary handshake.
    tbl.push_back(mk(1, 8,  2'b00, 0, 0, 0,  8, 1,  8, 8));
    tbl.push_back(mk(1, 15, 2'b00, 0, 0, 0, 23, 2, 15, 8));
    tbl.push_back(mk(1, 12, 2'b01, 0, 0, 0, 35, 3, 15, 8));
    tbl.push_back(mk(1, 14, 2'b01, 0, 0, 1, 49, 4, 15, 8));
    tbl.push_back(mk(0, 0,  2'b00, 0, 1, 0,  0, 0,  0, 255));
    // No-op skip: mode 11 samples are consumed but not counted.
    tbl.push_back(mk(1, 8,  2'b00, 0, 0, 0,  8, 1,  8, 8));
    tbl.push_back(mk(1, 0,  2'b11, 0, 0, 0,  8, 1,  8, 8));
    tbl.push_back(mk(1, 15, 2'b00, 0, 0, 0, 23, 2, 15, 8));
    tbl.push_back(mk(1, 0,  2'b11, 0, 0, 0, 23, 2, 15, 8));
    tbl.push_back(mk(1, 12, 2'b01, 0, 0, 0, 35, 3, 15, 8));
    tbl.push_back(mk(1, 14, 2'b01, 0, 0, 1, 49, 4, 15, 8));
    tbl.push_back(mk(0, 0,  2'b00, 0, 1, 0,  0, 0,  0, 255));
    // out_ready outside DONE has no effect.
    tbl.push_back(mk(1, 3,  2'b10, 0, 1, 0,  3, 1,  3, 3));
    tbl.push_back(mk(0, 0,  2'b00, 1, 0, 0,  0, 0,  0, 255));

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst.sum", sum_a, 0);
    check("rst.count", count_a, 0);
    check("rst.max", max_a, 0);
    check("rst.min", min_a, 255);
    check("rst.sat", sat_a, 0);
    check("rst.out_valid", out_valid_a, 0);
    rst_n = 1'b1;
    #1;
    check("rst.in_ready", in_ready_a, 1);

    // Table-driven vectors.
    foreach (tbl[i]) begin
      apply(tbl[i].v, tbl[i].y, tbl[i].m, tbl[i].clr, tbl[i].ordy);
      check($sformatf("tbl%0d.out_valid", i), out_valid_a, tbl[i].e_ov);
      check($sformatf("tbl%0d.in_ready", i), in_ready_a, !tbl[i].e_ov);
      check($sformatf("tbl%0d.sum", i), sum_a, tbl[i].e_sum);
      check($sformatf("tbl%0d.sum_b", i), sum_b, tbl[i].e_sum);
      check($sformatf("tbl%0d.count", i), count_a, tbl[i].e_cnt);
      check($sformatf("tbl%0d.max", i), max_a, tbl[i].e_max);
      check($sformatf("tbl%0d.min", i), min_a, tbl[i].e_min);
      check($sformatf("tbl%0d.sat", i), sat_a, 0);
    end

    // Saturation on the narrow build.
    feed(200, 2'b00, "sat1");
    feed(100, 2'b00, "sat2");
    check("sat.after_ovf.sum_b", sum_b, 255);
    check("sat.after_ovf.sat_b", sat_b, 1);
    feed(5, 2'b01, "sat3");
    feed(5, 2'b10, "sat4");
    check("sat.sum_b", sum_b, 255);
    check("sat.sat_b", sat_b, 1);
    check("sat.min_b", min_b, 5);
    check("sat.max_b", max_b, 200);
    check("sat.sum_a", sum_a, 310);
    check("sat.sat_a", sat_a, 0);
    apply(0, 0, 2'b00, 0, 1);
    check("sat.hs.sat_b", sat_b, 0);
    check("sat.hs.sum_b", sum_b, 0);

    // Hold in DONE with inputs offered, then release.
    feed(8, 2'b00, "hold_fill");
    feed(15, 2'b00, "hold_fill");
    feed(12, 2'b01, "hold_fill");
    feed(14, 2'b01, "hold_fill");
    for (int k = 0; k < 3; k++) begin
      apply(1, 9, 2'b00, 0, 0);
      check("hold.sum", sum_a, 49);
      check("hold.count", count_a, 4);
      check("hold.in_ready", in_ready_a, 0);
      check("hold.out_valid", out_valid_a, 1);
    end
    apply(1, 9, 2'b00, 0, 1);
    check("hold.rel.out_valid", out_valid_a, 0);
    check("hold.rel.sum", sum_a, 0);
    check("hold.rel.min", min_a, 255);
    check("hold.rel.in_ready", in_ready_a, 1);

    // Clear priority over an accept.
    feed(40, 2'b00, "clr_fill");
    feed(50, 2'b00, "clr_fill");
    apply(1, 7, 2'b00, 1, 0);
    check("clr.sum", sum_a, 0);
    check("clr.count", count_a, 0);
    check("clr.max", max_a, 0);
    // Clear together with out_ready in DONE.
    for (int k = 0; k < N; k++) feed(8'(k + 1), 2'b00, "clr_done_fill");
    apply(0, 0, 2'b00, 1, 1);
    check("clr_done.out_valid", out_valid_a, 0);
    check("clr_done.count", count_a, 0);
    check("clr_done.min", min_a, 255);

    // Async reset between edges, mid-batch.
    feed(30, 2'b00, "arst_fill");
    feed(60, 2'b01, "arst_fill");
    feed(90, 2'b10, "arst_fill");
    #2 rst_n = 1'b0;
    #1;
    check("arst.sum", sum_a, 0);
    check("arst.count", count_a, 0);
    check("arst.max", max_a, 0);
    check("arst.min", min_a, 255);
    check("arst.out_valid", out_valid_a, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    feed(20, 2'b00, "arst_batch");
    feed(3, 2'b01, "arst_batch");
    feed(0, 2'b11, "arst_batch");
    feed(77, 2'b10, "arst_batch");
    feed(5, 2'b00, "arst_batch");
    check("arst.fresh.sum", sum_a, 105);
    check("arst.fresh.min", min_a, 3);
    check("arst.fresh.max", max_a, 77);
    apply(0, 0, 2'b00, 0, 1);
    check_model("arst_hs");

    // Randomized stream against the model.
    for (int k = 0; k < 400; k++) begin
      apply(1'($urandom_range(0, 3) != 0),
            8'($urandom_range(0, 255)),
            2'($urandom_range(0, 3)),
            1'($urandom_range(0, 29) == 0),
            1'($urandom_range(0, 1)));
      check_model("rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
